// File: rtl/rev_alu_pkg.sv
// Shared types for the reversible ALU datapath.
// Defines the operation direction and the serial sequencer states.
package rev_alu_pkg;

   typedef enum logic {
      DIR_FWD = 1'b0,
      DIR_REV = 1'b1
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/rev_fa_cell.sv
// Reversible full-adder cell, purely combinational.
// Ports: a, b, c, s, cout in; s_fwd, cout_fwd, c_inv, chk out.
//   Forward:  (a,b,c)      -> s_fwd, cout_fwd
//   Inverse:  (a,b,s,cout) -> c_inv, chk (1 = cout inconsistent)
module rev_fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic s,
   input  logic cout,
   output logic s_fwd,
   output logic cout_fwd,
   output logic c_inv,
   output logic chk
);

   assign s_fwd    = a ^ b ^ c;
   assign cout_fwd = (a & b) | (a & c) | (b & c);

   // Recover the carry-in, then re-derive the carry-out from it and
   // compare against the carry-out we were handed.
   assign c_inv = s ^ a ^ b;
   assign chk   = ((a & b) | (a & c_inv) | (b & c_inv)) ^ cout;

endmodule

// File: rtl/rfa_serial_seq.sv
// Bit-serial sequencer time-sharing one reversible full-adder cell.
// Ports: clk, rst_n; req_valid/ready, req_dir, req_a/b/s, req_c;
//        rsp_valid/ready, rsp_s, rsp_c, rsp_err; busy.
module rfa_serial_seq
   import rev_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_dir,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [WIDTH-1:0] req_s,
   input  logic             req_c,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_s,
   output logic             rsp_c,
   output logic             rsp_err,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] IDX_LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   dir_e             dir_q, dir_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic             err_q, err_d;

   logic cell_s, cell_cout, cell_c, cell_chk;

   // Carry register feeds both the forward carry-in and the
   // inverse carry-out; only one is meaningful per direction.
   rev_fa_cell u_cell (
      .a        (a_q[idx_q]),
      .b        (b_q[idx_q]),
      .c        (carry_q),
      .s        (s_q[idx_q]),
      .cout     (carry_q),
      .s_fwd    (cell_s),
      .cout_fwd (cell_cout),
      .c_inv    (cell_c),
      .chk      (cell_chk)
   );

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_RUN;
               dir_d   = dir_e'(req_dir);
               a_d     = req_a;
               b_d     = req_b;
               s_d     = req_s;
               carry_d = req_c;
               err_d   = 1'b0;
               idx_d   = req_dir ? IDX_LAST : '0;
            end
         end
         ST_RUN: begin
            if (dir_q == DIR_FWD) begin
               s_d[idx_q] = cell_s;
               carry_d    = cell_cout;
               if (idx_q == IDX_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + CW'(1);
               end
            end else begin
               if (cell_chk) begin
                  err_d = 1'b1;
               end
               carry_d = cell_c;
               if (idx_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q - CW'(1);
               end
            end
         end
         ST_DONE: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_FWD;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign rsp_s     = s_q;
   assign rsp_c     = carry_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_rfa_serial_seq.sv
// Directed and random checks for the bit-serial reversible adder.
// Drives rfa_serial_seq at WIDTH=8 and checks responses.
module tb_rfa_serial_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_dir = 1'b0;
   logic [W-1:0] req_a = '0;
   logic [W-1:0] req_b = '0;
   logic [W-1:0] req_s = '0;
   logic         req_c = 1'b0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [W-1:0] rsp_s;
   logic         rsp_c;
   logic         rsp_err;
   logic         busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rfa_serial_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_dir   (req_dir),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_s     (req_s),
      .req_c     (req_c),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_s     (rsp_s),
      .rsp_c     (rsp_c),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request; returns edges from accept to rsp_valid
   // (99 if it never came). Leaves the DUT in DONE, sampled #1.
   task automatic issue(input logic dir, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] s,
                        input logic c, output int lat);
      req_dir   = dir;
      req_a     = a;
      req_b     = b;
      req_s     = s;
      req_c     = c;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 99;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic retire();
      @(posedge clk);
      #1;
   endtask

   int           lat;
   logic [W:0]   sum;
   logic [W-1:0] ra, rb, snap_s;
   logic         rc, snap_c, snap_e;
   bit           seen;
   int           rnd_bad;

   initial begin
      #12;
      chk("reset_ready", req_ready, 1);
      chk("reset_valid", rsp_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_s", rsp_s, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // FWD FF+01+0
      issue(1'b0, 8'hFF, 8'h01, 8'h00, 1'b0, lat);
      chk("fwd1_lat", lat, 8);
      chk("fwd1_s", rsp_s, 8'h00);
      chk("fwd1_c", rsp_c, 1);
      chk("fwd1_err", rsp_err, 0);
      chk("fwd1_rdy", req_ready, 0);
      retire();
      chk("fwd1_idle", req_ready, 1);

      // FWD 5A+3C+1 = 97
      issue(1'b0, 8'h5A, 8'h3C, 8'hAA, 1'b1, lat);
      chk("fwd2_lat", lat, 8);
      chk("fwd2_s", rsp_s, 8'h97);
      chk("fwd2_c", rsp_c, 0);
      chk("fwd2_err", rsp_err, 0);
      retire();

      // REV consistent
      issue(1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, lat);
      chk("rev1_lat", lat, 8);
      chk("rev1_s", rsp_s, 8'h00);
      chk("rev1_c", rsp_c, 0);
      chk("rev1_err", rsp_err, 0);
      retire();

      // REV with wrong cout
      issue(1'b1, 8'hFF, 8'h01, 8'h00, 1'b0, lat);
      chk("rev2_lat", lat, 8);
      chk("rev2_c", rsp_c, 0);
      chk("rev2_err", rsp_err, 1);
      retire();

      // REV 5A,3C,97,cout=0 -> cin=1
      issue(1'b1, 8'h5A, 8'h3C, 8'h97, 1'b0, lat);
      chk("rev3_c", rsp_c, 1);
      chk("rev3_err", rsp_err, 0);
      chk("rev3_s", rsp_s, 8'h97);
      retire();

      // Backpressure: hold DONE 5 cycles, offer a new request
      rsp_ready = 1'b0;
      issue(1'b0, 8'h12, 8'h34, 8'h00, 1'b0, lat);
      chk("bp_lat", lat, 8);
      chk("bp_s", rsp_s, 8'h46);
      req_dir   = 1'b1;
      req_a     = 8'hFF;
      req_b     = 8'hFF;
      req_s     = 8'hFF;
      req_c     = 1'b1;
      req_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("bp_valid", rsp_valid, 1);
         chk("bp_ready", req_ready, 0);
         chk("bp_hold_s", rsp_s, 8'h46);
         chk("bp_hold_c", rsp_c, 0);
         chk("bp_hold_e", rsp_err, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      retire();
      chk("bp_release", rsp_valid, 0);
      chk("bp_idle", req_ready, 1);
      @(posedge clk);
      #1;
      chk("bp_no_accept", busy, 0);

      // Reset in the middle of RUN, at bit 3
      req_dir   = 1'b0;
      req_a     = 8'hFF;
      req_b     = 8'hFF;
      req_c     = 1'b1;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_s", rsp_s, 0);
      chk("rst_c", rsp_c, 0);
      chk("rst_err", rsp_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (rsp_valid || busy) seen = 1'b1;
      end
      chk("rst_no_rsp", seen, 0);

      // Random round trips
      rnd_bad = 0;
      for (int i = 0; i < 1000; i++) begin
         ra  = W'($urandom_range(255));
         rb  = W'($urandom_range(255));
         rc  = 1'($urandom_range(1));
         sum = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
         issue(1'b0, ra, rb, 8'h00, rc, lat);
         snap_s = rsp_s;
         snap_c = rsp_c;
         snap_e = rsp_err;
         if (lat != 8 || snap_s !== sum[W-1:0] || snap_c !== sum[W]
             || snap_e !== 1'b0) begin
            rnd_bad++;
            chk("rnd_fwd_s", {23'b0, snap_c, snap_s}, {23'b0, sum});
            chk("rnd_fwd_lat", lat, 8);
         end
         retire();
         issue(1'b1, ra, rb, snap_s, snap_c, lat);
         if (lat != 8 || rsp_c !== rc || rsp_err !== 1'b0
             || rsp_s !== snap_s) begin
            rnd_bad++;
            chk("rnd_rev_c", rsp_c, rc);
            chk("rnd_rev_err", rsp_err, 0);
         end
         retire();
      end
      chk("rnd_total_bad", rnd_bad, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
